// File: rtl/fetch_stage_if.sv
// Instruction-fetch bus: hazard/redirect controls and instruction memory in,
// IF/ID register contents out.
// Optional macro FETCH_ALIGN_CHECK_EN adds the sticky Misalign flag.
interface fetch_stage_if;
    logic        Stall;
    logic        Flush;
    logic        Branch;
    logic [31:0] BranchTarget;
    logic [31:0] InstrIn;
    logic [31:0] PC;
    logic [31:0] InstrOut;
    logic [31:0] PCPlus4Out;
    logic        ValidOut;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        Misalign;
`endif

    // Control protocol: there is no valid/ready pair here. Stall is a hold
    // request from the hazard unit, Flush/Branch insert a bubble, and
    // ValidOut=0 marks a bubble that decode must treat as a no-op.

    // Fetch stage side.
    modport slave (
        input  Stall, Flush, Branch, BranchTarget, InstrIn,
        output PC, InstrOut, PCPlus4Out, ValidOut
`ifdef FETCH_ALIGN_CHECK_EN
        , output Misalign
`endif
    );

    // Hazard unit / instruction memory / decode side.
    modport master (
        output Stall, Flush, Branch, BranchTarget, InstrIn,
        input  PC, InstrOut, PCPlus4Out, ValidOut
`ifdef FETCH_ALIGN_CHECK_EN
        , input Misalign
`endif
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: program counter plus the IF/ID register.
// Priority per edge: reset > Branch > Stall > Flush > normal fetch.
// Optional macro FETCH_ALIGN_CHECK_EN: force redirect targets to word
// alignment and raise a sticky Misalign flag when a target was misaligned.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RST_N,
    fetch_stage_if.slave  bus
);

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;

    // Sequential successor address, wraps modulo 2^32.
    assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    // Redirect target with the byte offset dropped.
    assign redirect_pc  = {bus.BranchTarget[31:2], 2'b00};
    assign bus.Misalign = misalign_q;

    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            misalign_q <= 1'b0;
        end else if (bus.Branch && (bus.BranchTarget[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end
`else
    assign redirect_pc = bus.BranchTarget;
`endif

    // PC and IF/ID register update in control priority order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
        end else if (bus.Branch) begin
            pc_q       <= redirect_pc;
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
        end else if (bus.Stall) begin
            // PC holds; a simultaneous flush still bubbles IF/ID.
            if (bus.Flush) begin
                instr_q    <= NOP_INSTR;
                pc_plus4_q <= 32'd0;
                valid_q    <= 1'b0;
            end
        end else if (bus.Flush) begin
            pc_q       <= pc_plus4;
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_plus4;
            instr_q    <= bus.InstrIn;
            pc_plus4_q <= pc_plus4;
            valid_q    <= 1'b1;
        end
    end

    assign bus.PC         = pc_q;
    assign bus.InstrOut   = instr_q;
    assign bus.PCPlus4Out = pc_plus4_q;
    assign bus.ValidOut   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan sequence followed
// by randomized control traffic against a behavioural model.
// Honours FETCH_ALIGN_CHECK_EN when defined.
module tb_fetch_stage;

    localparam logic [31:0] MEM_KEY   = 32'hA5A5_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic CLK;
    logic RST_N;
    int   n_cmp;
    int   n_err;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // Instruction memory: word at address A is A ^ MEM_KEY.
    assign bus.InstrIn = bus.PC ^ MEM_KEY;

    // Clock / reset block.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference state: what the IF/ID register and PC should hold.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_p4;
    logic        m_valid;
    logic        m_mis;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic bubble_model();
        m_instr = NOP_INSTR;
        m_p4    = 32'd0;
        m_valid = 1'b0;
    endtask

    // Driver: apply one cycle of controls, advance the model, compare after the edge.
    task automatic step(input logic rst_n, input logic br, input logic [31:0] tgt,
                        input logic st, input logic fl);
        logic fetched;
        fetched      = 1'b0;
        RST_N        = rst_n;
        bus.Branch   = br;
        bus.BranchTarget = tgt;
        bus.Stall    = st;
        bus.Flush    = fl;
        if (!rst_n) begin
            m_pc  = RESET_PC;
            m_mis = 1'b0;
            bubble_model();
            exp_q.delete();
        end else if (br) begin
`ifdef FETCH_ALIGN_CHECK_EN
            m_pc = tgt - (tgt % 4);
            if (tgt % 4 != 0) m_mis = 1'b1;
`else
            m_pc = tgt;
`endif
            bubble_model();
        end else if (st) begin
            if (fl) bubble_model();
        end else if (fl) begin
            m_pc = m_pc + 32'd4;
            bubble_model();
        end else begin
            exp_q.push_back(m_pc ^ MEM_KEY);
            m_p4    = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            fetched = 1'b1;
        end
        @(posedge CLK);
        @(negedge CLK);
        if (fetched) m_instr = exp_q.pop_front();
        check("pc", bus.PC, m_pc);
        check("instr", bus.InstrOut, m_instr);
        check("pc4", bus.PCPlus4Out, m_p4);
        check("valid", {31'd0, bus.ValidOut}, {31'd0, m_valid});
`ifdef FETCH_ALIGN_CHECK_EN
        check("misalign", {31'd0, bus.Misalign}, {31'd0, m_mis});
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0; m_mis = 0;
        RST_N = 1'b0;
        bus.Stall = 0; bus.Flush = 0; bus.Branch = 0; bus.BranchTarget = 0;
        @(negedge CLK);

        // Reset and sequential fetch.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("rst_pc", bus.PC, 32'h0);
        step(1, 0, 0, 0, 0);
        check("first_instr", bus.InstrOut, 32'hA5A5_0000);
        check("first_pc4", bus.PCPlus4Out, 32'h4);
        step(1, 0, 0, 0, 0);
        check("pc_8", bus.PC, 32'h8);

        // Stall hold for three cycles, then advance.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 0);
            check("stall_instr", bus.InstrOut, 32'hA5A5_0004);
        end
        step(1, 0, 0, 0, 0);
        check("post_stall", bus.InstrOut, 32'hA5A5_0008);
        step(1, 0, 0, 0, 0);

        // Branch wins over a simultaneous stall.
        step(1, 1, 32'h100, 1, 0);
        check("br_pc", bus.PC, 32'h100);
        step(1, 0, 0, 0, 0);
        check("br_instr", bus.InstrOut, 32'hA5A5_0100);
        check("br_pc4", bus.PCPlus4Out, 32'h104);

        // Flush alone, then flush with stall.
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 1, 1);

        // Wrap-around of the PC.
        step(1, 1, 32'hFFFF_FFFC, 0, 0);
        step(1, 0, 0, 0, 0);
        check("wrap_pc", bus.PC, 32'h0);
        check("wrap_pc4", bus.PCPlus4Out, 32'h0);
        step(1, 0, 0, 0, 0);

        // Misaligned redirect, then reset in the middle of a stall.
        step(1, 1, 32'h203, 0, 0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("midrst_pc", bus.PC, RESET_PC);

        // Randomized control traffic.
        for (int i = 0; i < 400; i++) begin
            logic r, b, s, f;
            logic [31:0] t;
            r = ($urandom_range(0, 49) != 0);
            b = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 5) == 0);
            t = $urandom();
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            step(r, b, t, s, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
